fetch_unit: RTL and testbench

Instruction fetch stage for the multicycle RV32I core. It holds the fetch PC and the instruction register (IR), and runs a request/response handshake with instruction memory. It presents the captured instruction and its decoded fields to the controller's decode step, and takes jump/branch redirects from the datapath. It sits directly upstream of the controller: the controller requests a fetch and waits for `fetch_done` before decoding.

---
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage of the multicycle RV32I core. Holds the fetch PC and
// the instruction register, runs a single-outstanding request/response
// handshake with instruction memory, and accepts jump/branch redirects.
//
// Ports
//   clk              clock, all state changes on the rising edge
//   rst              synchronous active-low reset
//   fetch_req        controller asks for the next instruction (seen in IDLE)
//   fetch_done       one-cycle pulse: instr/pc hold a freshly captured word
//   pc_load          redirect strobe, next fetch comes from pc_target
//   pc_target        redirect address
//   imem_req_valid   read request valid (registered)
//   imem_req_ready   memory accepts the request
//   imem_addr        request address, stable while imem_req_valid is high
//   imem_rsp_valid   response valid
//   imem_rsp_data    response instruction word
//   instr            instruction register contents
//   pc               address of the instruction held in instr
//   pc_next          pc + 4 (link value)
//   opcode/rd/rs1/rs2/funct3/funct7  fixed slices of instr
//   misaligned       sticky flag, set by a redirect with target[1:0] != 0
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_req,
    output logic             fetch_done,
    input  logic             pc_load,
    input  logic [WIDTH-1:0] pc_target,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic             misaligned
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_e           state_q;
    logic [WIDTH-1:0] fetch_pc_q;
    logic [WIDTH-1:0] pc_q;
    logic [31:0]      ir_q;
    logic             redirect_pending_q;
    logic [WIDTH-1:0] redirect_addr_q;
    logic             misaligned_q;
    logic             fetch_done_q;
    logic             req_valid_q;

    logic [WIDTH-1:0] target_aligned_s;
    logic             target_misaligned_s;
    logic [WIDTH-1:0] fetch_pc_inc_s;

    // Redirect target alignment and sequential increment (wraps at 2^WIDTH).
    always_comb begin
        target_aligned_s    = {pc_target[WIDTH-1:2], 2'b00};
        target_misaligned_s = (pc_target[1:0] != 2'b00);
        fetch_pc_inc_s      = fetch_pc_q + WIDTH'(4);
    end

    // Fetch FSM with all registered state and outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q            <= S_IDLE;
            fetch_pc_q         <= RESET_PC;
            pc_q               <= RESET_PC;
            ir_q               <= NOP;
            redirect_pending_q <= 1'b0;
            redirect_addr_q    <= '0;
            misaligned_q       <= 1'b0;
            fetch_done_q       <= 1'b0;
            req_valid_q        <= 1'b0;
        end else begin
            fetch_done_q <= 1'b0;
            if (pc_load && target_misaligned_s) begin
                misaligned_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    // A redirect in IDLE retargets fetch_pc directly, so a
                    // simultaneous fetch_req issues to the new address.
                    if (pc_load) begin
                        fetch_pc_q <= target_aligned_s;
                    end
                    if (fetch_req) begin
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    // fetch_pc is the in-flight address; redirects are parked.
                    if (pc_load) begin
                        redirect_pending_q <= 1'b1;
                        redirect_addr_q    <= target_aligned_s;
                    end
                    if (imem_req_ready) begin
                        state_q     <= S_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        ir_q <= imem_rsp_data;
                        pc_q <= fetch_pc_q;
                        // A redirect arriving on the capture cycle is the
                        // newest one and wins over a parked redirect.
                        if (pc_load) begin
                            fetch_pc_q <= target_aligned_s;
                        end else if (redirect_pending_q) begin
                            fetch_pc_q <= redirect_addr_q;
                        end else begin
                            fetch_pc_q <= fetch_pc_inc_s;
                        end
                        redirect_pending_q <= 1'b0;
                        fetch_done_q       <= 1'b1;
                        state_q            <= S_IDLE;
                    end else if (pc_load) begin
                        redirect_pending_q <= 1'b1;
                        redirect_addr_q    <= target_aligned_s;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // fetch_pc is a register that only moves in IDLE or at capture, so it is
    // stable for the whole time imem_req_valid is high.
    assign imem_addr      = fetch_pc_q;
    assign imem_req_valid = req_valid_q;
    assign fetch_done     = fetch_done_q;
    assign misaligned     = misaligned_q;
    assign instr          = ir_q;
    assign pc             = pc_q;
    assign pc_next        = pc_q + WIDTH'(4);
    assign opcode         = ir_q[6:0];
    assign rd             = ir_q[11:7];
    assign funct3         = ir_q[14:12];
    assign rs1            = ir_q[19:15];
    assign rs2            = ir_q[24:20];
    assign funct7         = ir_q[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: a vector table of fetch transactions,
// hand-written sequences for mid-flight redirect and mid-fetch reset, and a
// randomized phase checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic        fetch_done;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req      (fetch_req),
        .fetch_done     (fetch_done),
        .pc_load        (pc_load),
        .pc_target      (pc_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr          (instr),
        .pc             (pc),
        .pc_next        (pc_next),
        .opcode         (opcode),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .funct3         (funct3),
        .funct7         (funct7),
        .misaligned     (misaligned)
    );

    typedef struct {
        logic        load;
        logic [31:0] tgt;
        int          rs;
        int          ds;
        logic [31:0] data;
        logic [31:0] exp_addr;
        logic        exp_mis;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete fetch; optional noise injects redirects and stray responses
    // during the stalls and reports them back for the reference model.
    task automatic run_fetch(input logic load, input logic [31:0] tgt,
                             input int rstall, input int dstall,
                             input logic [31:0] data, input logic [31:0] exp_addr,
                             input bit noise,
                             output bit redir, output logic [31:0] rtgt, output bit mis);
        logic [31:0] exp_link;
        redir = 1'b0;
        rtgt  = 32'h0;
        mis   = load && (tgt[1:0] != 2'b00);
        fetch_req = 1'b1; pc_load = load; pc_target = tgt;
        tick();
        fetch_req = 1'b0; pc_load = 1'b0;
        chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("req_addr", imem_addr, exp_addr);
        for (int i = 0; i < rstall; i++) begin
            if (noise) begin
                imem_rsp_valid = 1'($urandom_range(0, 1));
                imem_rsp_data  = $urandom;
                if ($urandom_range(0, 2) == 0) begin
                    pc_load = 1'b1; pc_target = $urandom;
                    redir = 1'b1; rtgt = pc_target;
                    if (pc_target[1:0] != 2'b00) mis = 1'b1;
                end
            end
            tick();
            imem_rsp_valid = 1'b0; pc_load = 1'b0;
            chk("addr_stable", imem_addr, exp_addr);
            chk("valid_held", {31'd0, imem_req_valid}, 32'd1);
            chk("no_done_req", {31'd0, fetch_done}, 32'd0);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("valid_drop", {31'd0, imem_req_valid}, 32'd0);
        chk("no_done_acc", {31'd0, fetch_done}, 32'd0);
        for (int i = 0; i < dstall; i++) begin
            if (noise && $urandom_range(0, 2) == 0) begin
                pc_load = 1'b1; pc_target = $urandom;
                redir = 1'b1; rtgt = pc_target;
                if (pc_target[1:0] != 2'b00) mis = 1'b1;
            end
            tick();
            pc_load = 1'b0;
            chk("no_done_wait", {31'd0, fetch_done}, 32'd0);
            chk("valid_low_wait", {31'd0, imem_req_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b1; imem_rsp_data = data;
        tick();
        imem_rsp_valid = 1'b0;
        exp_link = exp_addr + 32'd4;
        chk("fetch_done", {31'd0, fetch_done}, 32'd1);
        chk("instr", instr, data);
        chk("pc", pc, exp_addr);
        chk("pc_next", pc_next, exp_link);
        chk("opcode", {25'd0, opcode}, {25'd0, data[6:0]});
        chk("rd", {27'd0, rd}, {27'd0, data[11:7]});
        chk("funct3", {29'd0, funct3}, {29'd0, data[14:12]});
        chk("rs1", {27'd0, rs1}, {27'd0, data[19:15]});
        chk("rs2", {27'd0, rs2}, {27'd0, data[24:20]});
        chk("funct7", {25'd0, funct7}, {25'd0, data[31:25]});
        tick();
        chk("done_pulse", {31'd0, fetch_done}, 32'd0);
    endtask

    logic [31:0] m_next;
    logic        m_mis;
    logic [31:0] last_data;
    logic [31:0] r_tgt;
    logic [31:0] r_data;
    logic [31:0] r_addr;
    logic        r_load;
    bit          o_redir;
    bit          o_mis;
    logic [31:0] o_rtgt;

    initial begin
        tbl[0] = '{1'b0, 32'h0000_0000, 0, 0, 32'h0050_0093, 32'h0000_0000, 1'b0};
        tbl[1] = '{1'b0, 32'h0000_0000, 2, 2, 32'h00A0_0113, 32'h0000_0004, 1'b0};
        tbl[2] = '{1'b0, 32'h0000_0000, 2, 2, 32'h0020_81B3, 32'h0000_0008, 1'b0};
        tbl[3] = '{1'b1, 32'h0000_0100, 0, 0, 32'h4020_8233, 32'h0000_0100, 1'b0};
        tbl[4] = '{1'b0, 32'h0000_0000, 1, 0, 32'hFE01_0113, 32'h0000_0104, 1'b0};
        tbl[5] = '{1'b1, 32'h0000_0103, 0, 1, 32'h0000_0013, 32'h0000_0100, 1'b1};
        tbl[6] = '{1'b1, 32'hFFFF_FFFC, 0, 0, 32'h00C0_006F, 32'hFFFF_FFFC, 1'b1};
        tbl[7] = '{1'b0, 32'h0000_0000, 0, 0, 32'h0010_0073, 32'h0000_0000, 1'b1};

        rst = 1'b0; fetch_req = 1'b0; pc_load = 1'b0; pc_target = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        tick();
        tick();
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", pc, 32'h0000_0000);
        chk("rst_pc_next", pc_next, 32'h0000_0004);
        chk("rst_done", {31'd0, fetch_done}, 32'd0);
        chk("rst_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        rst = 1'b1;

        // Table-driven fetches: sequential, stalled, redirected, misaligned, wrap.
        for (int i = 0; i < 8; i++) begin
            run_fetch(tbl[i].load, tbl[i].tgt, tbl[i].rs, tbl[i].ds, tbl[i].data,
                      tbl[i].exp_addr, 1'b0, o_redir, o_rtgt, o_mis);
            chk("tbl_mis", {31'd0, misaligned}, {31'd0, tbl[i].exp_mis});
            if (i == 0) begin
                chk("first_opcode", {25'd0, opcode}, 32'h0000_0013);
                chk("first_rd", {27'd0, rd}, 32'd1);
                chk("first_rs1", {27'd0, rs1}, 32'd0);
            end
        end

        // Two redirects while awaiting the response: the capture keeps the old
        // address, and the later redirect decides the next fetch.
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("wr_addr", imem_addr, 32'h0000_0004);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        pc_load = 1'b1; pc_target = 32'h0000_0200;
        tick();
        pc_target = 32'h0000_0300;
        tick();
        pc_load = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        tick();
        imem_rsp_valid = 1'b0;
        chk("wr_done", {31'd0, fetch_done}, 32'd1);
        chk("wr_pc", pc, 32'h0000_0004);
        chk("wr_instr", instr, 32'h1234_5678);
        tick();
        run_fetch(1'b0, 32'h0, 0, 0, 32'h0000_00B3, 32'h0000_0300, 1'b0, o_redir, o_rtgt, o_mis);

        // Reset while waiting; the late response must be ignored.
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        chk("mr_done", {31'd0, fetch_done}, 32'd0);
        chk("mr_instr", instr, 32'h0000_0013);
        chk("mr_pc", pc, 32'h0000_0000);
        chk("mr_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("mr_mis", {31'd0, misaligned}, 32'd0);
        tick();
        chk("mr_done2", {31'd0, fetch_done}, 32'd0);
        run_fetch(1'b0, 32'h0, 0, 0, 32'h0000_0293, 32'h0000_0000, 1'b0, o_redir, o_rtgt, o_mis);

        // Randomized phase against a transaction-level model.
        m_next = 32'h0000_0004;
        m_mis = 1'b0;
        last_data = 32'h0000_0293;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                imem_rsp_valid = 1'b1; imem_rsp_data = $urandom;
                tick();
                imem_rsp_valid = 1'b0;
                chk("idle_rsp_done", {31'd0, fetch_done}, 32'd0);
                chk("idle_rsp_instr", instr, last_data);
            end
            r_load = ($urandom_range(0, 3) == 0);
            r_tgt  = $urandom;
            if ($urandom_range(0, 7) == 0) r_tgt = 32'hFFFF_FFFC;
            r_data = $urandom;
            r_addr = r_load ? (r_tgt & 32'hFFFF_FFFC) : m_next;
            run_fetch(r_load, r_tgt, $urandom_range(0, 3), $urandom_range(0, 3), r_data,
                      r_addr, 1'b1, o_redir, o_rtgt, o_mis);
            m_mis  = m_mis | o_mis;
            m_next = o_redir ? (o_rtgt & 32'hFFFF_FFFC) : (r_addr + 32'd4);
            last_data = r_data;
            chk("rnd_mis", {31'd0, misaligned}, {31'd0, m_mis});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
